// File: rtl/bus_mem_responder_if.sv
// bus_mem_responder_if: CPU memory bus between the cpu master and the memory responder.
interface bus_mem_responder_if;
    logic        ren;
    logic [15:0] addr;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wr_mask;
    modport master (output ren, addr, wen, wdata, wr_mask, input rdata, rd_valid);
    modport slave  (input ren, addr, wen, wdata, wr_mask, output rdata, rd_valid);
endinterface

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: bus slave serving byte-masked RAM writes, registered reads and an LED/cycle-counter MMIO window.
module bus_mem_responder #(
    parameter int          DEPTH        = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] MMIO_BASE    = 16'hFF00,
    parameter string       INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_mem_responder_if.slave  bus,
    output logic [7:0]          led
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q, hold_q, cyc_cnt, src;
    logic [13:0]   off_w;
    logic          is_mmio, in_ram, is_led, is_cyc, issue, wr;

    assign is_mmio = bus.addr >= MMIO_BASE;
    assign off_w   = bus.addr[15:2] - MMIO_BASE[15:2];
    assign in_ram  = !is_mmio && ({18'b0, bus.addr[15:2]} < DEPTH);
    assign is_led  = is_mmio && off_w == 14'd0;
    assign is_cyc  = is_mmio && off_w == 14'd1;
    assign issue   = state_q == IDLE && bus.ren;
    // A read request on the same edge always wins over a write.
    assign wr      = bus.wen && !bus.ren;
    assign src     = in_ram ? mem[bus.addr[AW+1:2]] : is_led ? {24'b0, led} : is_cyc ? cyc_cnt : 32'b0;

    assign bus.rd_valid = state_q == RESP;
    assign bus.rdata    = rdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.ren ? (READ_LATENCY == 1 ? RESP : WAIT) : IDLE;
            WAIT:    state_d = cnt_q <= 1 ? RESP : WAIT;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Source data is snapshotted at the issue edge; later writes never leak into that read.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            hold_q  <= '0;
            led     <= '0;
            cyc_cnt <= '0;
        end else begin
            state_q <= state_d;
            cyc_cnt <= cyc_cnt + 32'd1;
            if (issue) begin
                cnt_q <= CW'(READ_LATENCY - 1);
                if (READ_LATENCY == 1) rdata_q <= src;
                else hold_q <= src;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 1'b1;
                if (state_d == RESP) rdata_q <= hold_q;
            end
            if (wr && is_led && bus.wr_mask[3]) led <= bus.wdata[7:0];
        end

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (wr && in_ram && bus.wr_mask[3-i]) mem[bus.addr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
endmodule
